// File: rtl/song_pkg.sv
// Shared types and entry-field layout for the song sequencer.
package song_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PLAY  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam int PITCH_MSB = 13;
    localparam int PITCH_LSB = 11;
    localparam int NOTE_MSB  = 10;
    localparam int NOTE_LSB  = 4;
    localparam int DUR_W     = 4;

    localparam logic [DUR_W-1:0] END_DUR   = '0;
    localparam logic [2:0]       PITCH_RST = 3'b010;

    function automatic logic pitch_ok(input logic [2:0] p);
        return (p == 3'b001) || (p == 3'b010) || (p == 3'b100);
    endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable 32-bit down-counter with terminal-count flag; shared by PLAY and GAP.
module note_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_en,
    output logic        o_zero
);

    logic [31:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 32'd1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/song_sequencer.sv
// Autoplay controller: fetches song entries over req/ack and drives buzzer note/pitch
// for the encoded duration, with a silent gap, pause and abort.
//
// state | meaning
// IDLE  | waiting for start; buzzer silent
// FETCH | rom_req held until rom_ack; end marker returns to IDLE with done
// PLAY  | note/pitch driven for dur*BEAT_CYCLES unpaused cycles
// GAP   | note silent for GAP_CYCLES unpaused cycles, pitch held
module song_sequencer
    import song_pkg::*;
#(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [ADDR_W-1:0] song_base,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [13:0]       rom_data,
    output logic [6:0]        note,
    output logic [2:0]        pitch,
    output logic              busy,
    output logic              done
);

    localparam logic [31:0] BEAT     = 32'(BEAT_CYCLES);
    localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES) - 32'd1;

    state_t            r_state, w_state_n;
    logic [13:0]       r_entry, w_entry_n;
    logic [ADDR_W-1:0] r_addr, w_addr_n;
    logic              r_pause_q;
    logic              w_load, w_en, w_zero, w_done_n, w_run, w_valid;
    logic [31:0]       w_load_val, w_dur_load;
    logic [DUR_W-1:0]  w_dur;
    logic [6:0]        r_note, w_note_n;
    logic [2:0]        r_pitch, w_pitch_n;
    logic              r_rom_req, r_busy, r_done;

    // Timing follows the registered pause, so a cycle is counted exactly when note was shown.
    assign w_run      = !r_pause_q;
    assign w_dur      = rom_data[DUR_W-1:0];
    assign w_dur_load = 32'(w_dur) * BEAT - 32'd1;

    note_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_en),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_entry_n  = r_entry;
        w_addr_n   = r_addr;
        w_load     = 1'b0;
        w_load_val = '0;
        w_done_n   = 1'b0;
        w_en       = ((r_state == S_PLAY) || (r_state == S_GAP)) && w_run;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_n = S_FETCH;
                    w_addr_n  = song_base;
                end
            end
            S_FETCH: begin
                if (rom_ack) begin
                    w_entry_n = rom_data;
                    if (w_dur == END_DUR) begin
                        w_state_n = S_IDLE;
                        w_done_n  = 1'b1;
                    end else begin
                        w_state_n  = S_PLAY;
                        w_load     = 1'b1;
                        w_load_val = w_dur_load;
                    end
                end
            end
            S_PLAY: begin
                if (w_run && w_zero) begin
                    if (GAP_CYCLES != 0) begin
                        w_state_n  = S_GAP;
                        w_load     = 1'b1;
                        w_load_val = GAP_LOAD;
                    end else begin
                        w_state_n = S_FETCH;
                        w_addr_n  = r_addr + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (w_run && w_zero) begin
                    w_state_n = S_FETCH;
                    w_addr_n  = r_addr + 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        if (stop) begin
            w_state_n = S_IDLE;
            w_addr_n  = r_addr;
            w_load    = 1'b0;
            w_done_n  = 1'b0;
        end
    end

    assign w_note_n  = w_entry_n[NOTE_MSB:NOTE_LSB];
    assign w_pitch_n = w_entry_n[PITCH_MSB:PITCH_LSB];
    assign w_valid   = pitch_ok(w_pitch_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry   <= '0;
            r_addr    <= '0;
            r_pause_q <= 1'b0;
            r_note    <= '0;
            r_pitch   <= PITCH_RST;
            r_rom_req <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_entry   <= w_entry_n;
            r_addr    <= w_addr_n;
            r_pause_q <= pause;
            r_rom_req <= (w_state_n == S_FETCH);
            r_busy    <= (w_state_n != S_IDLE);
            r_done    <= w_done_n;
            r_note    <= ((w_state_n == S_PLAY) && !pause && w_valid) ? w_note_n : '0;
            // Pitch only ever takes a one-hot value; an invalid entry plays silent instead.
            if ((r_state == S_FETCH) && (w_state_n == S_PLAY) && w_valid) begin
                r_pitch <= w_pitch_n;
            end
        end
    end

    assign rom_req  = r_rom_req;
    assign rom_addr = r_addr;
    assign note     = r_note;
    assign pitch    = r_pitch;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
